// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: EX-stage op codes
// and the decoded-operation record used by mul_div_unit.
package mul_div_unit_pkg;

    localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

    typedef struct packed {
        logic valid;
        logic is_div;
        logic is_signed;
    } op_dec_t;

endpackage

// File: rtl/mul_div_unit_sign_fix.sv
// mdu_sign_fix: combinational conditional two's-complement negate, used both to
// take operand magnitudes and to restore result signs.
module mdu_sign_fix
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic             neg,
    output logic [WIDTH-1:0] y
);

    assign y = neg ? -a : a;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO writes.
// Define MDU_MUL_ITER_EN for a shift-add multiplier; otherwise multiply is one-shot.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OP_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             annul,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [1:0]         state_reg;
    logic [2*WIDTH-1:0] acc_reg;     // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
    logic [WIDTH-1:0]   b_reg;       // multiplicand or divisor magnitude
    logic [CNT_W-1:0]   cnt_reg;
    logic               neg_q_reg;
    logic               neg_r_reg;
    logic               dz_reg;
    logic               div_zero_reg;
    logic [WIDTH-1:0]   hi_reg;
    logic [WIDTH-1:0]   lo_reg;

    op_dec_t dec;
    logic    accept;
    logic    last;

    always_comb begin
        dec = '0;
        if (op == OP_W'(EXE_MULT_OP))       dec = '{valid: 1'b1, is_div: 1'b0, is_signed: 1'b1};
        else if (op == OP_W'(EXE_MULTU_OP)) dec = '{valid: 1'b1, is_div: 1'b0, is_signed: 1'b0};
        else if (op == OP_W'(EXE_DIV_OP))   dec = '{valid: 1'b1, is_div: 1'b1, is_signed: 1'b1};
        else if (op == OP_W'(EXE_DIVU_OP))  dec = '{valid: 1'b1, is_div: 1'b1, is_signed: 1'b0};
    end

    assign busy   = (state_reg == S_MUL) || (state_reg == S_DIV);
    assign done   = (state_reg == S_DONE);
    assign accept = start && !annul && dec.valid && !busy;
    assign last   = (cnt_reg == CNT_W'(1));

    // Operand magnitudes: index 0 is x, index 1 is y.
    logic [WIDTH-1:0] opnd [2];
    logic [WIDTH-1:0] mag  [2];
    assign opnd[0] = x;
    assign opnd[1] = y;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_abs
            mdu_sign_fix #(.WIDTH(WIDTH)) u_abs (
                .a   (opnd[gi]),
                .neg (dec.is_signed & opnd[gi][WIDTH-1]),
                .y   (mag[gi])
            );
        end
    endgenerate

    logic [2*WIDTH-1:0] mul_res;
`ifdef MDU_MUL_ITER_EN
    logic [WIDTH:0] mul_sum;
    assign mul_sum = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, b_reg} : '0);
    assign mul_res = {mul_sum, acc_reg[WIDTH-1:1]};
`else
    assign mul_res = (2*WIDTH)'(b_reg) * (2*WIDTH)'(acc_reg[WIDTH-1:0]);
`endif

    // Restoring step: trial-subtract the divisor from {remainder, next dividend bit}.
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] div_step;
    assign div_trial = acc_reg[2*WIDTH-1:WIDTH-1] - {1'b0, b_reg};

    always_comb begin
        div_step = {acc_reg[2*WIDTH-2:0], 1'b0};
        if (!div_trial[WIDTH])
            div_step = {div_trial[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
    end

    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quot_fixed;
    logic [WIDTH-1:0]   rem_fixed;

    mdu_sign_fix #(.WIDTH(2*WIDTH)) u_fix_prod (.a(mul_res),                     .neg(neg_q_reg), .y(prod_fixed));
    mdu_sign_fix #(.WIDTH(WIDTH))   u_fix_quot (.a(div_step[WIDTH-1:0]),         .neg(neg_q_reg), .y(quot_fixed));
    mdu_sign_fix #(.WIDTH(WIDTH))   u_fix_rem  (.a(div_step[2*WIDTH-1:WIDTH]),   .neg(neg_r_reg), .y(rem_fixed));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            acc_reg      <= '0;
            b_reg        <= '0;
            cnt_reg      <= '0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            dz_reg       <= 1'b0;
            div_zero_reg <= 1'b0;
            hi_reg       <= '0;
            lo_reg       <= '0;
        end else begin
            if (!busy && hi_we) hi_reg <= wdata;
            if (!busy && lo_we) lo_reg <= wdata;

            case (state_reg)
                S_MUL: begin
                    if (annul) begin
                        state_reg <= S_IDLE;
                    end else begin
`ifdef MDU_MUL_ITER_EN
                        acc_reg <= mul_res;
                        cnt_reg <= cnt_reg - 1'b1;
                        if (last) begin
                            {hi_reg, lo_reg} <= prod_fixed;
                            state_reg        <= S_DONE;
                        end
`else
                        {hi_reg, lo_reg} <= prod_fixed;
                        state_reg        <= S_DONE;
`endif
                    end
                end
                S_DIV: begin
                    if (annul) begin
                        state_reg <= S_IDLE;
                    end else if (dz_reg) begin
                        // Raw dividend was parked in the low half at accept time.
                        lo_reg       <= '1;
                        hi_reg       <= acc_reg[WIDTH-1:0];
                        div_zero_reg <= 1'b1;
                        state_reg    <= S_DONE;
                    end else begin
                        acc_reg <= div_step;
                        cnt_reg <= cnt_reg - 1'b1;
                        if (last) begin
                            lo_reg    <= quot_fixed;
                            hi_reg    <= rem_fixed;
                            state_reg <= S_DONE;
                        end
                    end
                end
                default: begin
                    if (accept) begin
                        state_reg    <= dec.is_div ? S_DIV : S_MUL;
                        cnt_reg      <= CNT_W'(WIDTH);
                        neg_q_reg    <= dec.is_signed & (x[WIDTH-1] ^ y[WIDTH-1]);
                        neg_r_reg    <= dec.is_signed & x[WIDTH-1];
                        dz_reg       <= dec.is_div & (y == '0);
                        div_zero_reg <= 1'b0;
                        b_reg        <= dec.is_div ? mag[1] : mag[0];
                        if (dec.is_div && y == '0)
                            acc_reg <= {{WIDTH{1'b0}}, x};
                        else
                            acc_reg <= {{WIDTH{1'b0}}, dec.is_div ? mag[0] : mag[1]};
                    end else begin
                        state_reg <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign hi       = hi_reg;
    assign lo       = lo_reg;
    assign div_zero = div_zero_reg;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed vectors push expected HI/LO/latency,
// a negedge monitor pops and compares on every done pulse.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    localparam int W = 32;
`ifdef MDU_MUL_ITER_EN
    localparam int MUL_LAT = W + 1;
`else
    localparam int MUL_LAT = 2;
`endif
    localparam int DIV_LAT = W + 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [7:0]   op = 8'h00;
    logic [W-1:0] x = '0;
    logic [W-1:0] y = '0;
    logic         annul = 1'b0;
    logic         hi_we = 1'b0;
    logic         lo_we = 1'b0;
    logic [W-1:0] wdata = '0;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;

    mul_div_unit #(.WIDTH(W), .OP_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .x(x), .y(y),
        .annul(annul), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string        name;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           start_cyc;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                $display("txn %-10s hi=%h lo=%h dz=%b lat=%0d", e.name, hi, lo, div_zero, cyc - e.start_cyc);
                check({e.name, ".hi"}, hi, e.hi);
                check({e.name, ".lo"}, lo, e.lo);
                check({e.name, ".dz"}, div_zero, e.dz);
                check({e.name, ".lat"}, cyc - e.start_cyc, e.lat);
            end
        end
    end

    // Called at a negedge; returns just after the accepting edge.
    task automatic issue(input string nm, input logic [7:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eh, input logic [W-1:0] el, input logic ed, input int lat);
        exp_t e;
        e.name = nm; e.hi = eh; e.lo = el; e.dz = ed; e.start_cyc = cyc; e.lat = lat;
        sb.push_back(e);
        op = o; x = a; y = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        check("done_timeout", got, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst.flags", {busy, done, div_zero}, 3'b000);
        check("rst.hi", hi, 0);
        check("rst.lo", lo, 0);
        rst = 1'b0;
        @(negedge clk);

        // Each issue after a wait_done lands in the DONE cycle: back-to-back starts.
        issue("mult",    EXE_MULT_OP,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, MUL_LAT); wait_done(40);
        issue("multu",   EXE_MULTU_OP, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 1'b0, MUL_LAT); wait_done(40);
        issue("mult_nn", EXE_MULT_OP,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, MUL_LAT); wait_done(40);
        issue("div_n7",  EXE_DIV_OP,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, DIV_LAT); wait_done(40);
        issue("div_7n2", EXE_DIV_OP,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, DIV_LAT); wait_done(40);
        issue("divu",    EXE_DIVU_OP,  32'd7,        32'd2,        32'h00000001, 32'h00000003, 1'b0, DIV_LAT); wait_done(40);
        issue("div_ovf", EXE_DIV_OP,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, DIV_LAT); wait_done(40);
        issue("divu_z",  EXE_DIVU_OP,  32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF, 1'b1, 2);       wait_done(5);

        // Next accepted start clears div_zero; a start while busy is ignored.
        issue("divu_b",  EXE_DIVU_OP,  32'd7,        32'd2,        32'h00000001, 32'h00000003, 1'b0, DIV_LAT);
        @(negedge clk);
        check("dz_cleared", div_zero, 0);
        check("busy_in_div", busy, 1);
        op = EXE_MULTU_OP; x = 32'hFFFFFFFE; y = 32'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(40);

        // MTHI / MTLO while idle.
        @(negedge clk); hi_we = 1'b1; wdata = 32'h1234;
        @(negedge clk); hi_we = 1'b0; lo_we = 1'b1; wdata = 32'hABCD;
        @(negedge clk); lo_we = 1'b0;
        check("mthi", hi, 32'h1234);
        check("mtlo", lo, 32'hABCD);

        // start with annul, and start with an unknown op, are both dropped.
        start = 1'b1; annul = 1'b1; op = EXE_DIVU_OP; x = 32'd7; y = 32'd2;
        @(negedge clk); annul = 1'b0; op = 8'h00;
        @(negedge clk); start = 1'b0;
        check("annul_start_dropped", busy, 0);
        op = EXE_DIV_OP;

        // DIV annulled on iteration 10: no done, HI/LO unchanged.
        x = 32'd100; y = 32'd7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("busy_before_annul", busy, 1);
        annul = 1'b1;
        @(posedge clk);
        #1 annul = 1'b0;
        @(negedge clk);
        check("busy_after_annul", busy, 0);
        repeat (40) @(negedge clk);
        check("annul.hi", hi, 32'h1234);
        check("annul.lo", lo, 32'hABCD);

        // MTHI in the start cycle lands first, then the result overwrites it.
        hi_we = 1'b1; wdata = 32'h5555;
        issue("divu_wr", EXE_DIVU_OP, 32'd7, 32'd2, 32'h00000001, 32'h00000003, 1'b0, DIV_LAT);
        hi_we = 1'b0;
        @(negedge clk);
        check("write_first.hi", hi, 32'h5555);
        wait_done(40);

        // Reset mid-divide clears everything immediately.
        @(negedge clk);
        op = EXE_DIV_OP; x = 32'hFFFFFFF9; y = 32'd2; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst.flags", {busy, done, div_zero}, 3'b000);
        check("midrst.hi", hi, 0);
        check("midrst.lo", lo, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue("divu_post", EXE_DIVU_OP, 32'd7, 32'd2, 32'h00000001, 32'h00000003, 1'b0, DIV_LAT); wait_done(40);

        @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
